// File: rtl/mem_access_pkg.sv
// Shared types and constants for the mem_access stage: funct3 access codes,
// trap causes, FSM states and the reset PC.
package mem_access_pkg;

  localparam int XLEN   = 64;
  localparam int STRB_W = XLEN / 8;

  localparam logic [XLEN-1:0] PMEM_START = 64'h0000_0000_8000_0000;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [XLEN-1:0] CAUSE_LOAD_MISALIGN  = 64'd4;
  localparam logic [XLEN-1:0] CAUSE_LOAD_FAULT     = 64'd5;
  localparam logic [XLEN-1:0] CAUSE_STORE_MISALIGN = 64'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Offset bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 3'b000;
      2'd1:    size_mask = 3'b001;
      2'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: store strobes/data shift, load extraction and extension,
// misalignment detect (only reported when MEM_MISALIGN_TRAP_EN is defined).
module mem_access_align
  import mem_access_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [2:0]        off_i,
  input  logic [XLEN-1:0]   sdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   ldata_o,
  output logic              misalign_o
);

  logic [2:0]        mask;
  logic [2:0]        eff_off;
  logic [5:0]        shamt;
  logic [STRB_W-1:0] base_strb;
  logic [XLEN-1:0]   rsh;

  always_comb begin
    mask    = size_mask(funct3_i[1:0]);
    // Aligning down is harmless in the trap build: a misaligned op never reaches the bus.
    eff_off = off_i & ~mask;
    shamt   = {eff_off, 3'b000};
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_o = |(off_i & mask);
`else
    misalign_o = 1'b0;
`endif
    case (funct3_i[1:0])
      2'd0:    base_strb = 8'h01;
      2'd1:    base_strb = 8'h03;
      2'd2:    base_strb = 8'h0F;
      default: base_strb = 8'hFF;
    endcase
    wstrb_o = base_strb << eff_off;
    wdata_o = sdata_i << shamt;
    rsh     = rdata_i >> shamt;
    case (funct3_i)
      F3_B:    ldata_o = {{56{rsh[7]}},  rsh[7:0]};
      F3_H:    ldata_o = {{48{rsh[15]}}, rsh[15:0]};
      F3_W:    ldata_o = {{32{rsh[31]}}, rsh[31:0]};
      F3_D:    ldata_o = rsh;
      F3_BU:   ldata_o = {56'd0, rsh[7:0]};
      F3_HU:   ldata_o = {48'd0, rsh[15:0]};
      F3_WU:   ldata_o = {32'd0, rsh[31:0]};
      default: ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one load/store per instruction on a valid/ready bus, stalling upstream
// while outstanding. MEM_MISALIGN_TRAP_EN turns misaligned accesses into traps instead of aligning down.
module mem_access
  import mem_access_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   aluout_i,
  input  logic [XLEN-1:0]   sdata_i,
  input  logic              wen_i,
  input  logic [4:0]        rd_i,
  input  logic              exception_i,
  input  logic [XLEN-1:0]   cause_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic              dreq_valid_o,
  input  logic              dreq_ready_i,
  output logic              dreq_we_o,
  output logic [XLEN-1:0]   dreq_addr_o,
  output logic [XLEN-1:0]   dreq_wdata_o,
  output logic [STRB_W-1:0] dreq_wstrb_o,
  input  logic              drsp_valid_i,
  input  logic [XLEN-1:0]   drsp_rdata_i,
  output logic              stall_o,
  output logic              wen_o,
  output logic [4:0]        rd_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              exception_o,
  output logic [XLEN-1:0]   cause_o,
  output logic [XLEN-1:0]   pc_o
);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic              wen_q, wen_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic              idle;
  logic              mem_op;
  logic              load_fault;
  logic              trap_misalign;
  logic [2:0]        al_funct3;
  logic [2:0]        al_off;
  logic [STRB_W-1:0] al_wstrb;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_ldata;
  logic              al_misalign;

  assign idle          = (state_q == ST_IDLE);
  assign mem_op        = (load_i | store_i) & ~exception_i;
  assign load_fault    = mem_op & load_i & (funct3_i == F3_BAD);
  assign trap_misalign = mem_op & ~load_fault & al_misalign;

  // One lane unit: fed by the incoming op while idle, by the captured op afterwards.
  assign al_funct3 = idle ? funct3_i      : funct3_q;
  assign al_off    = idle ? aluout_i[2:0] : addr_q[2:0];

  mem_access_align u_align (
    .funct3_i   (al_funct3),
    .off_i      (al_off),
    .sdata_i    (sdata_i),
    .rdata_i    (drsp_rdata_i),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .ldata_o    (al_ldata),
    .misalign_o (al_misalign)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    wen_d    = wen_q;
    rd_d     = rd_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    pc_d     = pc_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !load_fault && !trap_misalign) begin
          we_d     = ~load_i;
          wen_d    = wen_i & load_i;
          rd_d     = rd_i;
          funct3_d = funct3_i;
          addr_d   = aluout_i;
          wdata_d  = al_wdata;
          wstrb_d  = load_i ? '0 : al_wstrb;
          pc_d     = pc_i;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dreq_ready_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (drsp_valid_i) begin
          rdata_d = al_ldata;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced to their reset values while reset is held, so an access is dropped at once.
  always_comb begin
    dreq_valid_o = 1'b0;
    dreq_we_o    = 1'b0;
    dreq_addr_o  = '0;
    dreq_wdata_o = '0;
    dreq_wstrb_o = '0;
    stall_o      = 1'b0;
    wen_o        = 1'b0;
    rd_o         = '0;
    wdata_o      = '0;
    exception_o  = 1'b0;
    cause_o      = '0;
    pc_o         = PMEM_START;
    if (reset) begin
      case (state_q)
        ST_IDLE: begin
          rd_o    = rd_i;
          pc_o    = pc_i;
          wdata_o = aluout_i;
          if (load_fault) begin
            exception_o = 1'b1;
            cause_o     = CAUSE_LOAD_FAULT;
          end else if (trap_misalign) begin
            exception_o = 1'b1;
            cause_o     = load_i ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
          end else if (mem_op) begin
            stall_o = 1'b1;
          end else begin
            wen_o       = wen_i;
            exception_o = exception_i;
            cause_o     = cause_i;
          end
        end
        ST_REQ: begin
          dreq_valid_o = 1'b1;
          dreq_we_o    = we_q;
          dreq_addr_o  = {addr_q[XLEN-1:3], 3'b000};
          dreq_wdata_o = wdata_q;
          dreq_wstrb_o = wstrb_q;
          stall_o      = 1'b1;
          rd_o         = rd_q;
          pc_o         = pc_q;
        end
        ST_RESP: begin
          stall_o = 1'b1;
          rd_o    = rd_q;
          pc_o    = pc_q;
        end
        default: begin
          wen_o   = wen_q;
          rd_o    = rd_q;
          wdata_o = rdata_q;
          pc_o    = pc_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      wen_q    <= 1'b0;
      rd_q     <= '0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      pc_q     <= PMEM_START;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      wen_q    <= wen_d;
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      pc_q     <= pc_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; inputs change on the falling edge,
// outputs are sampled 1ns later.
module tb_mem_access;

  localparam logic [63:0] PMEM_EXP = 64'h0000_0000_8000_0000;
  localparam logic [63:0] PC_EXP   = 64'h0000_0000_8000_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_i, store_i, wen_i, exception_i;
  logic [2:0]  funct3_i;
  logic [63:0] aluout_i, sdata_i, cause_i, pc_i;
  logic [4:0]  rd_i;
  logic        dreq_valid_o, dreq_ready_i, dreq_we_o;
  logic [63:0] dreq_addr_o, dreq_wdata_o;
  logic [7:0]  dreq_wstrb_o;
  logic        drsp_valid_i;
  logic [63:0] drsp_rdata_i;
  logic        stall_o, wen_o, exception_o;
  logic [4:0]  rd_o;
  logic [63:0] wdata_o, cause_o, pc_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clock        (clk),
    .reset        (reset),
    .load_i       (load_i),
    .store_i      (store_i),
    .funct3_i     (funct3_i),
    .aluout_i     (aluout_i),
    .sdata_i      (sdata_i),
    .wen_i        (wen_i),
    .rd_i         (rd_i),
    .exception_i  (exception_i),
    .cause_i      (cause_i),
    .pc_i         (pc_i),
    .dreq_valid_o (dreq_valid_o),
    .dreq_ready_i (dreq_ready_i),
    .dreq_we_o    (dreq_we_o),
    .dreq_addr_o  (dreq_addr_o),
    .dreq_wdata_o (dreq_wdata_o),
    .dreq_wstrb_o (dreq_wstrb_o),
    .drsp_valid_i (drsp_valid_i),
    .drsp_rdata_i (drsp_rdata_i),
    .stall_o      (stall_o),
    .wen_o        (wen_o),
    .rd_o         (rd_o),
    .wdata_o      (wdata_o),
    .exception_o  (exception_o),
    .cause_o      (cause_o),
    .pc_o         (pc_o)
  );

  task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] sd, input logic [4:0] rd);
    load_i = ld; store_i = st; funct3_i = f3; aluout_i = addr; sdata_i = sd;
    rd_i = rd; wen_i = 1'b1; exception_i = 1'b0; cause_i = 64'd0; pc_i = PC_EXP;
  endtask

  task automatic clear_op();
    load_i = 0; store_i = 0; funct3_i = 0; aluout_i = 0; sdata_i = 0; rd_i = 0;
    wen_i = 0; exception_i = 0; cause_i = 0; pc_i = 0;
    dreq_ready_i = 0; drsp_valid_i = 0; drsp_rdata_i = 0;
  endtask

  // Runs a load with immediate ready/response and returns what is presented at T+3.
  task automatic do_load(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] rdata,
                         output logic [63:0] res, output logic res_wen);
    @(negedge clk);
    set_op(1, 0, f3, addr, 64'd0, 5'd9);
    dreq_ready_i = 1; drsp_valid_i = 1; drsp_rdata_i = rdata;
    repeat (3) @(negedge clk);
    #1;
    res = wdata_o; res_wen = wen_o;
    @(negedge clk);
    clear_op();
  endtask

  task automatic test_reset();
    reset = 0;
    set_op(0, 0, 3'b000, 64'h55, 64'h0, 5'd3);
    dreq_ready_i = 0; drsp_valid_i = 0; drsp_rdata_i = 0;
    @(negedge clk); #1;
    checks++; if (dreq_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", dreq_valid_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0h exp=0", stall_o); end
    checks++; if (wen_o !== 1'b0 || rd_o !== 5'd0) begin errors++; $display("FAIL rst_wen_rd got=%0h/%0h exp=0/0", wen_o, rd_o); end
    checks++; if (wdata_o !== 64'd0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", wdata_o); end
    checks++; if (pc_o !== PMEM_EXP) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc_o, PMEM_EXP); end
    @(negedge clk);
    reset = 1;
    clear_op();
  endtask

  task automatic test_ld();
    @(negedge clk);
    set_op(1, 0, 3'b011, 64'h8000_1000, 64'd0, 5'd10);
    dreq_ready_i = 1; drsp_valid_i = 1; drsp_rdata_i = 64'h1122334455667788;
    #1;
    checks++; if (stall_o !== 1'b1 || dreq_valid_o !== 1'b0) begin errors++; $display("FAIL ld_T stall/valid got=%0h/%0h exp=1/0", stall_o, dreq_valid_o); end
    @(negedge clk); #1;
    checks++; if (stall_o !== 1'b1 || dreq_valid_o !== 1'b1) begin errors++; $display("FAIL ld_T1 stall/valid got=%0h/%0h exp=1/1", stall_o, dreq_valid_o); end
    checks++; if (dreq_addr_o !== 64'h8000_1000 || dreq_we_o !== 1'b0 || dreq_wstrb_o !== 8'h00) begin errors++; $display("FAIL ld_req addr/we/strb got=%h/%0h/%h exp=80001000/0/00", dreq_addr_o, dreq_we_o, dreq_wstrb_o); end
    checks++; if (wen_o !== 1'b0) begin errors++; $display("FAIL ld_bubble_wen got=%0h exp=0", wen_o); end
    @(negedge clk); #1;
    checks++; if (stall_o !== 1'b1 || dreq_valid_o !== 1'b0) begin errors++; $display("FAIL ld_T2 stall/valid got=%0h/%0h exp=1/0", stall_o, dreq_valid_o); end
    @(negedge clk); #1;
    checks++; if (stall_o !== 1'b0 || wen_o !== 1'b1 || rd_o !== 5'd10) begin errors++; $display("FAIL ld_T3 stall/wen/rd got=%0h/%0h/%0d exp=0/1/10", stall_o, wen_o, rd_o); end
    checks++; if (wdata_o !== 64'h1122334455667788) begin errors++; $display("FAIL ld_data got=%h exp=1122334455667788", wdata_o); end
    @(negedge clk);
    clear_op();
  endtask

  task automatic test_lb_lbu();
    logic [63:0] res;
    logic        w;
    do_load(3'b000, 64'h8000_1007, 64'h80AA_BBCC_DDEE_FF11, res, w);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FF80 || w !== 1'b1) begin errors++; $display("FAIL lb_sext got=%h wen=%0h exp=ffffffffffffff80 wen=1", res, w); end
    do_load(3'b100, 64'h8000_1007, 64'h80AA_BBCC_DDEE_FF11, res, w);
    checks++; if (res !== 64'h80) begin errors++; $display("FAIL lbu_zext got=%h exp=80", res); end
    do_load(3'b101, 64'h8000_1002, 64'h0000_0000_9ABC_0000, res, w);
    checks++; if (res !== 64'h9ABC) begin errors++; $display("FAIL lhu_off2 got=%h exp=9abc", res); end
  endtask

  task automatic test_sh();
    @(negedge clk);
    set_op(0, 1, 3'b001, 64'h8000_1002, 64'hBEEF, 5'd4);
    dreq_ready_i = 1; drsp_valid_i = 1; drsp_rdata_i = 64'h0;
    @(negedge clk); #1;
    checks++; if (dreq_wstrb_o !== 8'h0C) begin errors++; $display("FAIL sh_strb got=%h exp=0c", dreq_wstrb_o); end
    checks++; if (dreq_wdata_o !== 64'hBEEF_0000 || dreq_we_o !== 1'b1) begin errors++; $display("FAIL sh_wdata/we got=%h/%0h exp=beef0000/1", dreq_wdata_o, dreq_we_o); end
    checks++; if (dreq_addr_o !== 64'h8000_1000) begin errors++; $display("FAIL sh_addr got=%h exp=80001000", dreq_addr_o); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wen_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL sh_done wen/stall got=%0h/%0h exp=0/0", wen_o, stall_o); end
    @(negedge clk);
    clear_op();
  endtask

  task automatic test_ready_stall();
    @(negedge clk);
    set_op(1, 0, 3'b010, 64'h8000_2004, 64'd0, 5'd6);
    dreq_ready_i = 0; drsp_valid_i = 1; drsp_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (dreq_valid_o !== 1'b1 || dreq_addr_o !== 64'h8000_2000 || stall_o !== 1'b1) begin
        errors++; $display("FAIL hold_req%0d valid/addr/stall got=%0h/%h/%0h exp=1/80002000/1", i, dreq_valid_o, dreq_addr_o, stall_o);
      end
    end
    @(negedge clk);
    dreq_ready_i = 1; drsp_rdata_i = 64'hDEAD_BEEF_1234_5678;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wdata_o !== 64'hFFFF_FFFF_DEAD_BEEF || wen_o !== 1'b1) begin errors++; $display("FAIL hold_lw got=%h wen=%0h exp=ffffffffdeadbeef wen=1", wdata_o, wen_o); end
    @(negedge clk);
    clear_op();
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    set_op(1, 0, 3'b010, 64'h8000_3002, 64'd0, 5'd2);
    dreq_ready_i = 1; drsp_valid_i = 1;
    #1;
    checks++; if (exception_o !== 1'b1 || cause_o !== 64'd4 || stall_o !== 1'b0) begin errors++; $display("FAIL lw_mis exc/cause/stall got=%0h/%0d/%0h exp=1/4/0", exception_o, cause_o, stall_o); end
    checks++; if (pc_o !== PC_EXP) begin errors++; $display("FAIL lw_mis_pc got=%h exp=%h", pc_o, PC_EXP); end
    @(negedge clk);
    set_op(0, 1, 3'b011, 64'h8000_3004, 64'd0, 5'd0);
    #1;
    checks++; if (dreq_valid_o !== 1'b0) begin errors++; $display("FAIL lw_mis_nobus got=%0h exp=0", dreq_valid_o); end
    checks++; if (exception_o !== 1'b1 || cause_o !== 64'd6) begin errors++; $display("FAIL sd_mis exc/cause got=%0h/%0d exp=1/6", exception_o, cause_o); end
    @(negedge clk);
    clear_op();
    #1;
    checks++; if (dreq_valid_o !== 1'b0 || exception_o !== 1'b0) begin errors++; $display("FAIL sd_mis_nobus valid/exc got=%0h/%0h exp=0/0", dreq_valid_o, exception_o); end
`else
    logic [63:0] res;
    logic        w;
    do_load(3'b010, 64'h8000_3002, 64'h1111_2222_3333_4444, res, w);
    checks++; if (res !== 64'h3333_4444) begin errors++; $display("FAIL lw_aligndown got=%h exp=33334444", res); end
`endif
  endtask

  task automatic test_fault_and_pass();
    @(negedge clk);
    set_op(1, 0, 3'b111, 64'h8000_4000, 64'd0, 5'd1);
    dreq_ready_i = 1; drsp_valid_i = 1;
    #1;
    checks++; if (exception_o !== 1'b1 || cause_o !== 64'd5 || stall_o !== 1'b0) begin errors++; $display("FAIL f3_111 exc/cause/stall got=%0h/%0d/%0h exp=1/5/0", exception_o, cause_o, stall_o); end
    @(negedge clk); #1;
    checks++; if (dreq_valid_o !== 1'b0) begin errors++; $display("FAIL f3_111_nobus got=%0h exp=0", dreq_valid_o); end
    set_op(0, 0, 3'b000, 64'h1234, 64'd0, 5'd7);
    #1;
    checks++; if (wen_o !== 1'b1 || rd_o !== 5'd7 || wdata_o !== 64'h1234 || stall_o !== 1'b0) begin
      errors++; $display("FAIL pass wen/rd/wdata/stall got=%0h/%0d/%h/%0h exp=1/7/1234/0", wen_o, rd_o, wdata_o, stall_o);
    end
    @(negedge clk);
    set_op(1, 0, 3'b011, 64'h8000_5000, 64'd0, 5'd7);
    exception_i = 1; cause_i = 64'd2;
    #1;
    checks++; if (exception_o !== 1'b1 || cause_o !== 64'd2 || stall_o !== 1'b0) begin errors++; $display("FAIL exc_in exc/cause/stall got=%0h/%0d/%0h exp=1/2/0", exception_o, cause_o, stall_o); end
    @(negedge clk); #1;
    checks++; if (dreq_valid_o !== 1'b0) begin errors++; $display("FAIL exc_in_nobus got=%0h exp=0", dreq_valid_o); end
    clear_op();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_op(1, 0, 3'b011, 64'h8000_6000, 64'd0, 5'd5);
    dreq_ready_i = 1; drsp_valid_i = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    checks++; if (dreq_valid_o !== 1'b0 || stall_o !== 1'b0 || wen_o !== 1'b0) begin errors++; $display("FAIL midrst valid/stall/wen got=%0h/%0h/%0h exp=0/0/0", dreq_valid_o, stall_o, wen_o); end
    checks++; if (pc_o !== PMEM_EXP || wdata_o !== 64'd0) begin errors++; $display("FAIL midrst pc/wdata got=%h/%h exp=%h/0", pc_o, wdata_o, PMEM_EXP); end
    @(negedge clk);
    reset = 1;
    clear_op();
    aluout_i = 64'hABCD; drsp_valid_i = 1; drsp_rdata_i = 64'h5555_5555_5555_5555;
    #1;
    checks++; if (stall_o !== 1'b0 || wdata_o !== 64'hABCD) begin errors++; $display("FAIL midrst_idle stall/wdata got=%0h/%h exp=0/abcd", stall_o, wdata_o); end
    @(negedge clk); #1;
    checks++; if (wen_o !== 1'b0 || wdata_o !== 64'hABCD || dreq_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_late wen/wdata/valid got=%0h/%h/%0h exp=0/abcd/0", wen_o, wdata_o, dreq_valid_o); end
    clear_op();
  endtask

  initial begin
    test_reset();
    test_ld();
    test_lb_lbu();
    test_sh();
    test_ready_stall();
    test_misalign();
    test_fault_and_pass();
    test_reset_mid();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
